// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants for the fetch queue and its neighbours.
// Purpose : entry field widths, the compressed-instruction detect constant,
//           the default predictor index width and the queue occupancy view.
// Contents: INST_W, ADDR_W, PRED_TABLE_BIT, INST_FULL_OPC,
//           fq_state_e (EMPTY / NONEMPTY), is_compressed().
package fetch_queue_pkg;

  localparam int INST_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int PRED_TABLE_BIT = 10;

  // A 32-bit instruction has both low opcode bits set; anything else is a
  // 16-bit compressed encoding.
  localparam logic [1:0] INST_FULL_OPC = 2'b11;

  typedef enum logic {
    FQ_EMPTY    = 1'b0,
    FQ_NONEMPTY = 1'b1
  } fq_state_e;

  function automatic logic is_compressed(input logic [INST_W-1:0] inst);
    return inst[1:0] != INST_FULL_OPC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and issue.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable, freezes state)
//   clear                        flush: empties the queue, pointers back to 0
//   enq_valid, enq_inst/pc/pred/target/g_ind/l_ind   fetch side
//   full, almost_full            occupancy flags for the fetch side to gate on
//   deq_ready, deq_valid, deq_inst/pc/pred/target/g_ind/l_ind, deq_is_c
//   count                        current occupancy
//
// Handshake: an enqueue happens on a rising edge where enq_valid is high, the
// queue is not full (or a dequeue frees a slot that same edge), clear is low
// and rdy_in is high; an enq_valid that does not fire is simply dropped.
// A dequeue happens on an edge where deq_valid and deq_ready are both high,
// clear is low and rdy_in is high.
//
// deq_* are registered copies of the head entry, so a new entry becomes
// visible one cycle after it is written (no same-cycle bypass).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int PRED_W    = PRED_TABLE_BIT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear,
  input  logic                       enq_valid,
  input  logic [INST_W-1:0]          enq_inst,
  input  logic [ADDR_W-1:0]          enq_pc,
  input  logic                       enq_pred,
  input  logic [ADDR_W-1:0]          enq_target,
  input  logic [PRED_W-1:0]          enq_g_ind,
  input  logic [PRED_W-1:0]          enq_l_ind,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [INST_W-1:0]          deq_inst,
  output logic [ADDR_W-1:0]          deq_pc,
  output logic                       deq_pred,
  output logic [ADDR_W-1:0]          deq_target,
  output logic [PRED_W-1:0]          deq_g_ind,
  output logic [PRED_W-1:0]          deq_l_ind,
  output logic                       deq_is_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage: flat per-field register arrays, no reset needed since
  // deq_valid qualifies every read.
  logic [INST_W-1:0] mem_inst_q   [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q     [DEPTH];
  logic              mem_pred_q   [DEPTH];
  logic [ADDR_W-1:0] mem_target_q [DEPTH];
  logic [PRED_W-1:0] mem_g_q      [DEPTH];
  logic [PRED_W-1:0] mem_l_q      [DEPTH];
  logic              mem_is_c_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fq_state_e         state_q, state_d;

  logic [INST_W-1:0] head_inst_q, head_inst_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              head_pred_q, head_pred_d;
  logic [ADDR_W-1:0] head_target_q, head_target_d;
  logic [PRED_W-1:0] head_g_q, head_g_d;
  logic [PRED_W-1:0] head_l_q, head_l_d;
  logic              head_is_c_q, head_is_c_d;

  logic clear_act, enq_fire, deq_fire;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
  assign deq_valid   = (state_q == FQ_NONEMPTY);
  assign count       = count_q;

  assign clear_act = clear && rdy_in;
  assign deq_fire  = deq_valid && deq_ready && !clear && rdy_in;
  assign enq_fire  = enq_valid && (!full || deq_fire) && !clear && rdy_in;

  // Pointer and occupancy next-state; count is tracked on its own so that
  // full and empty stay distinguishable when the pointers coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_act) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // EMPTY / NONEMPTY occupancy view; drives deq_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FQ_EMPTY: begin
        if (enq_fire) state_d = FQ_NONEMPTY;
      end
      FQ_NONEMPTY: begin
        if (clear_act) state_d = FQ_EMPTY;
        else if (deq_fire && !enq_fire && count_q == CNT_W'(1)) state_d = FQ_EMPTY;
      end
      default: state_d = FQ_EMPTY;
    endcase
  end

  // Next head contents. If the slot that becomes head is the one being
  // written this edge (queue empty, or count==1 with a dequeue), the
  // incoming fields are forwarded into the head register.
  always_comb begin
    head_inst_d   = head_inst_q;
    head_pc_d     = head_pc_q;
    head_pred_d   = head_pred_q;
    head_target_d = head_target_q;
    head_g_d      = head_g_q;
    head_l_d      = head_l_q;
    head_is_c_d   = head_is_c_q;
    if (rdy_in) begin
      if (enq_fire && (wr_ptr_q == rd_ptr_d)) begin
        head_inst_d   = enq_inst;
        head_pc_d     = enq_pc;
        head_pred_d   = enq_pred;
        head_target_d = enq_target;
        head_g_d      = enq_g_ind;
        head_l_d      = enq_l_ind;
        head_is_c_d   = is_compressed(enq_inst);
      end else begin
        head_inst_d   = mem_inst_q[rd_ptr_d];
        head_pc_d     = mem_pc_q[rd_ptr_d];
        head_pred_d   = mem_pred_q[rd_ptr_d];
        head_target_d = mem_target_q[rd_ptr_d];
        head_g_d      = mem_g_q[rd_ptr_d];
        head_l_d      = mem_l_q[rd_ptr_d];
        head_is_c_d   = mem_is_c_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      mem_inst_q[wr_ptr_q]   <= enq_inst;
      mem_pc_q[wr_ptr_q]     <= enq_pc;
      mem_pred_q[wr_ptr_q]   <= enq_pred;
      mem_target_q[wr_ptr_q] <= enq_target;
      mem_g_q[wr_ptr_q]      <= enq_g_ind;
      mem_l_q[wr_ptr_q]      <= enq_l_ind;
      mem_is_c_q[wr_ptr_q]   <= is_compressed(enq_inst);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= FQ_EMPTY;
      head_inst_q   <= '0;
      head_pc_q     <= '0;
      head_pred_q   <= 1'b0;
      head_target_q <= '0;
      head_g_q      <= '0;
      head_l_q      <= '0;
      head_is_c_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      head_inst_q   <= head_inst_d;
      head_pc_q     <= head_pc_d;
      head_pred_q   <= head_pred_d;
      head_target_q <= head_target_d;
      head_g_q      <= head_g_d;
      head_l_q      <= head_l_d;
      head_is_c_q   <= head_is_c_d;
    end
  end

  assign deq_inst   = head_inst_q;
  assign deq_pc     = head_pc_q;
  assign deq_pred   = head_pred_q;
  assign deq_target = head_target_q;
  assign deq_g_ind  = head_g_q;
  assign deq_l_ind  = head_l_q;
  assign deq_is_c   = head_is_c_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue (DEPTH=8, AF_THRESH=6, PRED_W=10).
// Reference model: a queue of packed entries updated with the enqueue /
// dequeue / clear / enable rules; every check compares the DUT against it
// or against constants.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int PW    = 10;
  localparam int ENT_W = 2*PW + 97;
  localparam int OFF_L = 0;
  localparam int OFF_G = PW;
  localparam int OFF_T = 2*PW;
  localparam int OFF_PRED = 2*PW + 32;
  localparam int OFF_PC   = 2*PW + 33;
  localparam int OFF_INST = 2*PW + 65;

  logic clk, rst_n, rdy, clear, enq_valid, enq_pred, deq_ready;
  logic [31:0] enq_inst, enq_pc, enq_target;
  logic [PW-1:0] enq_g, enq_l;
  logic full, almost_full, deq_valid, deq_pred, deq_is_c;
  logic [31:0] deq_inst, deq_pc, deq_target;
  logic [PW-1:0] deq_g, deq_l;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;
  logic [ENT_W-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .AF_THRESH(AF), .PRED_W(PW)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear(clear),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_pred(enq_pred), .enq_target(enq_target),
    .enq_g_ind(enq_g), .enq_l_ind(enq_l),
    .full(full), .almost_full(almost_full),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pred(deq_pred),
    .deq_target(deq_target), .deq_g_ind(deq_g), .deq_l_ind(deq_l),
    .deq_is_c(deq_is_c), .count(count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  function automatic logic [3:0] exp_cnt();
    return 4'(exp_q.size());
  endfunction
  function automatic logic [31:0] hd_pc();
    logic [ENT_W-1:0] e;
    e = exp_q[0];
    return e[OFF_PC +: 32];
  endfunction
  function automatic logic [31:0] hd_inst();
    logic [ENT_W-1:0] e;
    e = exp_q[0];
    return e[OFF_INST +: 32];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    enq_valid  = v;
    enq_pc     = pc;
    enq_inst   = inst;
    enq_pred   = 1'($urandom_range(0, 1));
    enq_target = $urandom;
    enq_g      = PW'($urandom);
    enq_l      = PW'($urandom);
  endtask

  // Advance one clock: apply the queue rules to the model with the inputs
  // present at the edge, then settle just after the edge.
  task automatic cycle();
    logic do_deq, do_enq;
    if (!rst_n) exp_q.delete();
    else if (rdy) begin
      if (clear) exp_q.delete();
      else begin
        do_deq = (exp_q.size() != 0) && deq_ready;
        do_enq = enq_valid && ((exp_q.size() < DEPTH) || do_deq);
        if (do_deq) void'(exp_q.pop_front());
        if (do_enq) exp_q.push_back({enq_inst, enq_pc, enq_pred, enq_target, enq_g, enq_l});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; rdy = 1'b0; clear = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0, 32'h13);
    #1 rst_n = 1'b0;
    #2;
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", deq_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_flags: got full=%0b af=%0b expected 0/0", full, almost_full); end
    checks++; if (deq_pc !== 32'h0 || deq_inst !== 32'h0 || deq_is_c !== 1'b0) begin failures++; $display("FAIL reset_fields: got pc=%0h inst=%0h c=%0b expected 0", deq_pc, deq_inst, deq_is_c); end
    rdy = 1'b1; deq_ready = 1'b1;
    set_enq(1'b1, 32'hABC, 32'h13);
    cycle(); cycle();
    checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL reset_hold: got count=%0d valid=%0b expected 0/0", count, deq_valid); end
    set_enq(1'b0, 32'h0, 32'h13);
    deq_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    deq_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_enq(1'b1, 32'h1000 + 32'(i * 4), {$urandom_range(0, 32'h3FFFFFFF), 2'b11});
      if (i == 0) begin
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL fill_no_bypass: got %0b expected 0", deq_valid); end
      end
      cycle();
      checks++; if (count !== exp_cnt()) begin failures++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, exp_cnt()); end
      checks++; if (full !== (exp_q.size() == DEPTH)) begin failures++; $display("FAIL fill_full[%0d]: got %0b", i, full); end
      checks++; if (almost_full !== (exp_q.size() >= AF)) begin failures++; $display("FAIL fill_af[%0d]: got %0b", i, almost_full); end
      checks++; if (deq_valid !== 1'b1 || deq_pc !== hd_pc()) begin failures++; $display("FAIL fill_head[%0d]: got v=%0b pc=%0h expected pc=%0h", i, deq_valid, deq_pc, hd_pc()); end
    end
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fill_final: got count=%0d full=%0b expected 8/1", count, full); end
  endtask

  task automatic test_full_swap();
    set_enq(1'b1, 32'h100, 32'h00000013);
    deq_ready = 1'b1;
    cycle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL swap_count: got %0d expected 8", count); end
    checks++; if (deq_pc !== 32'h1004) begin failures++; $display("FAIL swap_head: got %0h expected 1004", deq_pc); end
    set_enq(1'b0, 32'h0, 32'h13);
    for (int k = 0; k < 8; k++) begin
      checks++; if (deq_pc !== hd_pc()) begin failures++; $display("FAIL drain_pc[%0d]: got %0h expected %0h", k, deq_pc, hd_pc()); end
      if (k == 7) begin
        checks++; if (deq_pc !== 32'h100) begin failures++; $display("FAIL swap_eighth: got %0h expected 100", deq_pc); end
      end
      cycle();
    end
    checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got count=%0d v=%0b expected 0/0", count, deq_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc;
    next_pc = 32'h0;
    deq_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) set_enq(1'b1, 32'(i * 4), {$urandom_range(0, 32'h3FFFFFFF), 2'b11});
      else set_enq(1'b0, 32'h0, 32'h13);
      if (deq_valid) begin
        checks++; if (deq_pc !== next_pc) begin failures++; $display("FAIL wrap_order: got %0h expected %0h", deq_pc, next_pc); end
        next_pc = next_pc + 32'd4;
      end
      cycle();
      checks++; if (count > 4'd1 || count !== exp_cnt()) begin failures++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, exp_cnt()); end
    end
    checks++; if (next_pc !== 32'h50) begin failures++; $display("FAIL wrap_total: got next=%0h expected 50", next_pc); end
    deq_ready = 1'b0;
  endtask

  task automatic test_compressed();
    deq_ready = 1'b0;
    set_enq(1'b1, 32'h2000, 32'h00004501);
    cycle();
    set_enq(1'b1, 32'h2002, 32'h00000013);
    cycle();
    set_enq(1'b0, 32'h0, 32'h13);
    checks++; if (deq_is_c !== 1'b1 || deq_inst !== 32'h4501) begin failures++; $display("FAIL c_first: got c=%0b inst=%0h expected 1/4501", deq_is_c, deq_inst); end
    deq_ready = 1'b1;
    cycle();
    checks++; if (deq_is_c !== 1'b0 || deq_inst !== hd_inst()) begin failures++; $display("FAIL c_second: got c=%0b inst=%0h expected 0/%0h", deq_is_c, deq_inst, hd_inst()); end
    cycle();
    deq_ready = 1'b0;
  endtask

  task automatic test_clear();
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(1'b1, 32'h3000 + 32'(i * 4), 32'h13);
      cycle();
    end
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL clr_pre: got %0d expected 5", count); end
    clear = 1'b1; deq_ready = 1'b1;
    set_enq(1'b1, 32'hDEAD0, 32'h13);
    cycle();
    clear = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0, 32'h13);
    checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL clr_empty: got count=%0d v=%0b expected 0/0", count, deq_valid); end
    cycle();
    checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL clr_absent: got count=%0d v=%0b expected 0/0", count, deq_valid); end
    set_enq(1'b1, 32'h200, 32'h13);
    cycle();
    set_enq(1'b0, 32'h0, 32'h13);
    checks++; if (count !== 4'd1 || deq_pc !== 32'h200) begin failures++; $display("FAIL clr_restart: got count=%0d pc=%0h expected 1/200", count, deq_pc); end
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
  endtask

  task automatic test_rdy_hold();
    deq_ready = 1'b0;
    set_enq(1'b1, 32'h300, 32'h13); cycle();
    set_enq(1'b1, 32'h304, 32'h13); cycle();
    rdy = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear = (i == 1);
      set_enq(1'b1, 32'h500 + 32'(i), 32'h13);
      cycle();
      checks++; if (count !== 4'd2 || deq_pc !== 32'h300 || deq_valid !== 1'b1) begin failures++; $display("FAIL rdy_hold[%0d]: got count=%0d pc=%0h v=%0b expected 2/300/1", i, count, deq_pc, deq_valid); end
    end
    rdy = 1'b1; clear = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0, 32'h13);
  endtask

  task automatic test_random();
    logic [ENT_W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      set_enq($urandom_range(0, 99) < 60, $urandom, $urandom);
      deq_ready = $urandom_range(0, 99) < 50;
      clear     = $urandom_range(0, 99) < 3;
      rdy       = $urandom_range(0, 99) < 90;
      cycle();
      checks++; if (count !== exp_cnt()) begin failures++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, exp_cnt()); end
      checks++; if (deq_valid !== (exp_q.size() != 0) || full !== (exp_q.size() == DEPTH) || almost_full !== (exp_q.size() >= AF)) begin
        failures++; $display("FAIL rnd_flags[%0d]: got v=%0b f=%0b af=%0b size=%0d", i, deq_valid, full, almost_full, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checks++;
        if (deq_inst !== e[OFF_INST +: 32] || deq_pc !== e[OFF_PC +: 32] || deq_pred !== e[OFF_PRED] ||
            deq_target !== e[OFF_T +: 32] || deq_g !== e[OFF_G +: PW] || deq_l !== e[OFF_L +: PW] ||
            deq_is_c !== (e[OFF_INST +: 2] != 2'b11)) begin
          failures++; $display("FAIL rnd_head[%0d]: got pc=%0h inst=%0h c=%0b expected pc=%0h inst=%0h", i, deq_pc, deq_inst, deq_is_c, e[OFF_PC +: 32], e[OFF_INST +: 32]);
        end
      end
    end
    rdy = 1'b1; clear = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0, 32'h13);
  endtask

  task automatic test_reset_mid();
    deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h4000 + 32'(i * 4), 32'h13);
      cycle();
    end
    set_enq(1'b0, 32'h0, 32'h13);
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got v=%0b expected 1", deq_valid); end
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (deq_valid !== 1'b0 || count !== 4'd0 || deq_pc !== 32'h0) begin failures++; $display("FAIL rstmid_async: got v=%0b count=%0d pc=%0h expected 0/0/0", deq_valid, count, deq_pc); end
    cycle();
    rst_n = 1'b1;
    set_enq(1'b1, 32'h400, 32'h13);
    cycle();
    set_enq(1'b0, 32'h0, 32'h13);
    checks++; if (count !== 4'd1 || deq_pc !== 32'h400 || deq_valid !== 1'b1) begin failures++; $display("FAIL rstmid_first: got count=%0d pc=%0h v=%0b expected 1/400/1", count, deq_pc, deq_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_full_swap();
    test_wrap();
    test_compressed();
    test_clear();
    test_rdy_hold();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 8, number of entries (power of two, >=2); AF_THRESH, default DEPTH-2, occupancy at which almost_full asserts; PRED_W, default `PRED_TABLE_BIT, predictor index width.
REQ-002 Ports SHALL be, in order:
clk_in  in  1  sole clock, rising edge;
rst_in  in  1  asynchronous reset, active-low;
rdy_in  in  1  global enable, state frozen when low;
clear  in  1  pipeline flush from rob;
enq_valid  in  1  fetched instruction present;
enq_inst  in  32  raw instruction (bits[1:0]!=2'b11 means compressed);
enq_pc  in  32  instruction address;
enq_pred  in  1  predicted taken;
enq_target  in  32  predicted target;
enq_g_ind  in  PRED_W  global predictor index;
enq_l_ind  in  PRED_W  local predictor index;
full  out  1  count==DEPTH;
almost_full  out  1  count>=AF_THRESH;
deq_ready  in  1  issue stage accepts head;
deq_valid  out  1  head entry valid;
deq_inst, deq_pc, deq_pred, deq_target, deq_g_ind, deq_l_ind  out  as enq_*  head fields;
deq_is_c  out  1  head is compressed;
count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-003 Enqueue SHALL fire when enq_valid && (!full || deq fire) && !clear && rdy_in; a non-firing enq_valid is dropped, and the fetch side SHALL gate with full/almost_full.
REQ-004 Dequeue SHALL fire when deq_valid && deq_ready && !clear && rdy_in.
REQ-005 deq_* SHALL be registered head-entry contents; deq_valid = (count!=0); enqueue-to-deq_valid latency SHALL be one cycle, with no same-cycle bypass.
REQ-006 Simultaneous enqueue and dequeue SHALL leave count unchanged, including at count==DEPTH (write slot freed by the read) and count==1 (head advances to new entry next cycle).
REQ-007 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be maintained explicitly, never derived from pointer difference alone.
REQ-008 deq_is_c SHALL be computed at enqueue from enq_inst[1:0] and stored per entry.
REQ-009 clear SHALL take priority over enqueue and dequeue: the next cycle count=0, both pointers=0, deq_valid=0; entry contents need not be erased.
REQ-010 rdy_in low SHALL hold all state and outputs, clear included; clear is sampled only when rdy_in is high.
REQ-011 Dequeue with count==0 and enqueue with full and no dequeue SHALL never alter state.
REQ-012 A two-state view SHALL apply: EMPTY (count==0) and NONEMPTY. EMPTY->NONEMPTY on enqueue. NONEMPTY->EMPTY on clear, or on dequeue at count==1 with no enqueue.

Reset
REQ-013 While rst_in is low, regardless of clock: pointers=0, count=0, deq_valid=0, full=0, almost_full=0 (AF_THRESH>0), all deq_* fields=0.
REQ-014 The first enqueue after release SHALL be accepted on the first rising edge with rst_in high and rdy_in high.
REQ-015 Reset asserted mid-operation SHALL discard all entries with no partial dequeue visible.

Structure
REQ-016 Entry field widths and the compressed-detect constant SHALL come from the shared const.v header; PRED_W defaults to `PRED_TABLE_BIT from it.
REQ-017 Storage SHALL be a flat register array of DEPTH entries inside fetch_queue. No sub-module is required; the pointer/count logic stays inline.
REQ-018 The instruction unit SHALL consume deq_* in place of direct memory-unit instruction inputs and SHALL drive deq_ready from !(rob_full||rs_full||lsb_full) && !stall.

Verification
REQ-019 Fill from reset, DEPTH=8, 8 enqueues with deq_ready=0 -> full=1 after 8th edge, almost_full=1 after 6th, 9th enq_valid dropped, count=8.
REQ-020 At full, same-cycle enq (pc=0x100) and deq -> count stays 8, head advances by one, entry 0x100 dequeued as 8th.
REQ-021 Wrap: 20 back-to-back enq/deq with pc=0,4,... -> deq_pc order 0..0x4C with no gaps, count stays <=1.
REQ-022 clear with count=5 plus simultaneous enq_valid -> next cycle count=0, deq_valid=0, the enqueued entry is absent.
REQ-023 Enqueue enq_inst=0x00004501 (c.li) then 0x00000013 -> deq_is_c=1 then 0.
REQ-024 rdy_in=0 for 3 cycles with enq_valid=1, deq_ready=1, count=2 -> count and deq_pc unchanged; rst_in pulled low mid-stream -> deq_valid=0 before the next edge.
